// File: rtl/alu_arbiter_if.sv
// Request/response handshakes for two requesters plus the shared-ALU hookup.
// The arbiter uses the slave view; a requester/ALU environment uses the master view.
interface alu_arbiter_if #(
  parameter int ALU_WIDTH = 32
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [ALU_WIDTH-1:0] req0_op1;
  logic [ALU_WIDTH-1:0] req0_op2;
  logic [3:0]           req0_alu_op;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [ALU_WIDTH-1:0] req1_op1;
  logic [ALU_WIDTH-1:0] req1_op2;
  logic [3:0]           req1_alu_op;
  logic                 resp0_valid;
  logic                 resp0_ready;
  logic [ALU_WIDTH-1:0] resp0_data;
  logic                 resp1_valid;
  logic                 resp1_ready;
  logic [ALU_WIDTH-1:0] resp1_data;
  logic [ALU_WIDTH-1:0] alu_op1;
  logic [ALU_WIDTH-1:0] alu_op2;
  logic [3:0]           alu_op;
  logic [ALU_WIDTH-1:0] alu_out;

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_alu_op,
    input  req1_valid, req1_op1, req1_op2, req1_alu_op,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_data, resp1_valid, resp1_data,
    input  resp0_ready, resp1_ready,
    output alu_op1, alu_op2, alu_op,
    input  alu_out
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_alu_op,
    output req1_valid, req1_op1, req1_op2, req1_alu_op,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_data, resp1_valid, resp1_data,
    output resp0_ready, resp1_ready,
    input  alu_op1, alu_op2, alu_op,
    output alu_out
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC samples the ALU, RESP holds the result.
module alu_arbiter #(
  parameter int ALU_WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_arbiter_if.slave  bus,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic                 last_grant;
  logic                 grant;
  logic                 accept;
  logic                 resp_hs;

  logic [ALU_WIDTH-1:0] op1_p0;
  logic [ALU_WIDTH-1:0] op2_p0;
  logic [3:0]           op_p0;
  logic                 id_p0;
  logic [ALU_WIDTH-1:0] res_p1;

  // Favour the requester that did not win last time only when both contend.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
    accept  = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    resp_hs = (state == RESP) && (id_p0 ? bus.resp1_ready : bus.resp0_ready);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (resp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: capture the granted request at the handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op1_p0     <= '0;
      op2_p0     <= '0;
      op_p0      <= '0;
      id_p0      <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      op1_p0     <= grant ? bus.req1_op1    : bus.req0_op1;
      op2_p0     <= grant ? bus.req1_op2    : bus.req0_op2;
      op_p0      <= grant ? bus.req1_alu_op : bus.req0_alu_op;
      id_p0      <= grant;
      last_grant <= grant;
    end
  end

  // Stage p1: sample the shared ALU during EXEC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_p1 <= '0;
    end else if (state == EXEC) begin
      res_p1 <= bus.alu_out;
    end
  end

  // Ready is gated by reset_n so nothing is offered while reset is held.
  always_comb begin
    bus.req0_ready  = 1'b0;
    bus.req1_ready  = 1'b0;
    bus.resp0_valid = 1'b0;
    bus.resp1_valid = 1'b0;
    bus.resp0_data  = '0;
    bus.resp1_data  = '0;
    bus.alu_op1     = '0;
    bus.alu_op2     = '0;
    bus.alu_op      = '0;
    busy            = (state != IDLE);
    case (state)
      IDLE: begin
        bus.req0_ready = reset_n && bus.req0_valid && !grant;
        bus.req1_ready = reset_n && bus.req1_valid && grant;
      end
      EXEC: begin
        bus.alu_op1 = op1_p0;
        bus.alu_op2 = op2_p0;
        bus.alu_op  = op_p0;
      end
      RESP: begin
        if (id_p0) begin
          bus.resp1_valid = 1'b1;
          bus.resp1_data  = res_p1;
        end else begin
          bus.resp0_valid = 1'b1;
          bus.resp0_data  = res_p1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of grant order, latency and result delivery.
module tb_alu_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  int   errors = 0;
  int   checks = 0;
  bit   model_last = 1'b1;

  logic [3:0]   cur_op [2];
  logic [W-1:0] cur_a  [2];
  logic [W-1:0] cur_b  [2];

  alu_arbiter_if #(.ALU_WIDTH(W)) bus();

  alu_arbiter #(.ALU_WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // ALU encoding: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU; 10-15 give 0.
  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return W'($signed(a) >>> b[4:0]);
      4'd8: return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd9: return {{(W-1){1'b0}}, (a < b)};
      default: return '0;
    endcase
  endfunction

  always_comb bus.alu_out = alu_ref(bus.alu_op, bus.alu_op1, bus.alu_op2);

  function automatic logic [1:0] onehot(input int g);
    return (g == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_req(input int n, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic v);
    cur_op[n] = op; cur_a[n] = a; cur_b[n] = b;
    if (n == 0) begin
      bus.req0_alu_op = op; bus.req0_op1 = a; bus.req0_op2 = b; bus.req0_valid = v;
    end else begin
      bus.req1_alu_op = op; bus.req1_op1 = a; bus.req1_op2 = b; bus.req1_valid = v;
    end
  endtask

  task automatic rand_req(input int n);
    logic v;
    v = (n == 0) ? bus.req0_valid : bus.req1_valid;
    set_req(n, 4'($urandom_range(0, 9)), $urandom, $urandom, v);
  endtask

  task automatic quiet();
    set_req(0, 4'd0, '0, '0, 1'b0);
    set_req(1, 4'd0, '0, '0, 1'b0);
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic test_reset();
    quiet();
    reset_n = 1'b0;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.resp0_ready = 1'b1;
    step(); #1;
    checks++; if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, busy} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=00000", {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, busy}); end
    checks++; if ({bus.resp0_data, bus.resp1_data} !== '0) begin errors++; $display("FAIL reset_resp_data got=%h exp=0", {bus.resp0_data, bus.resp1_data}); end
    checks++; if ({bus.alu_op1, bus.alu_op2, bus.alu_op} !== '0) begin errors++; $display("FAIL reset_alu got=%h exp=0", {bus.alu_op1, bus.alu_op2, bus.alu_op}); end
    quiet();
    step();
    reset_n = 1'b1;
    model_last = 1'b1;
  endtask

  task automatic test_single();
    quiet(); step();
    set_req(0, 4'd0, 32'd5, 32'd7, 1'b1); bus.resp0_ready = 1'b1; #1;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin errors++; $display("FAIL single_accept got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    step(); #1;
    checks++; if ({busy, bus.req0_ready, bus.resp0_valid} !== 3'b100) begin errors++; $display("FAIL single_exec_ctrl got=%b exp=100", {busy, bus.req0_ready, bus.resp0_valid}); end
    checks++; if ({bus.alu_op1, bus.alu_op2, bus.alu_op} !== {32'd5, 32'd7, 4'd0}) begin errors++; $display("FAIL single_alu_drive got=%h exp=%h", {bus.alu_op1, bus.alu_op2, bus.alu_op}, {32'd5, 32'd7, 4'd0}); end
    step(); #1;
    checks++; if ({bus.resp0_valid, bus.resp1_valid} !== 2'b10) begin errors++; $display("FAIL single_resp_valid got=%b exp=10", {bus.resp0_valid, bus.resp1_valid}); end
    checks++; if (bus.resp0_data !== 32'd12) begin errors++; $display("FAIL single_resp_data got=%0d exp=12", bus.resp0_data); end
    checks++; if ({bus.alu_op1, bus.alu_op2, bus.alu_op} !== '0) begin errors++; $display("FAIL single_alu_idle got=%h exp=0", {bus.alu_op1, bus.alu_op2, bus.alu_op}); end
    step(); #1;
    checks++; if ({busy, bus.req0_ready} !== 2'b01) begin errors++; $display("FAIL single_reaccept got=%b exp=01", {busy, bus.req0_ready}); end
    bus.req0_valid = 1'b0;
    model_last = 1'b0;
  endtask

  task automatic test_contention();
    do_reset();
    set_req(0, 4'd1, 32'd10, 32'd3, 1'b1);
    set_req(1, 4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1);
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1; #1;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin errors++; $display("FAIL cont_first_grant got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    step(); #1;
    checks++; if ({bus.req1_ready, bus.req0_ready, busy} !== 3'b001) begin errors++; $display("FAIL cont_exec_ready got=%b exp=001", {bus.req1_ready, bus.req0_ready, busy}); end
    step(); #1;
    checks++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b01) begin errors++; $display("FAIL cont_resp0_valid got=%b exp=01", {bus.resp1_valid, bus.resp0_valid}); end
    checks++; if (bus.resp0_data !== 32'd7 || bus.resp1_data !== '0) begin errors++; $display("FAIL cont_resp0_data got=%h/%h exp=7/0", bus.resp0_data, bus.resp1_data); end
    step(); #1;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin errors++; $display("FAIL cont_second_grant got=%b exp=10", {bus.req1_ready, bus.req0_ready}); end
    bus.req0_valid = 1'b0;
    step(); bus.req1_valid = 1'b0;
    step(); #1;
    checks++; if ({bus.resp1_valid, bus.resp0_valid} !== 2'b10) begin errors++; $display("FAIL cont_resp1_valid got=%b exp=10", {bus.resp1_valid, bus.resp0_valid}); end
    checks++; if (bus.resp1_data !== '0 || bus.resp0_data !== '0) begin errors++; $display("FAIL cont_resp1_data got=%h/%h exp=0/0", bus.resp1_data, bus.resp0_data); end
    step(); quiet();
    model_last = 1'b1;
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    rand_req(0); rand_req(1);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int g;
      logic [W-1:0] want;
      logic [W-1:0] got;
      logic [W-1:0] other;
      #1;
      g = i % 2;
      checks++; if ({bus.req1_ready, bus.req0_ready} !== onehot(g)) begin errors++; $display("FAIL rr_grant op%0d got=%b exp=%b", i, {bus.req1_ready, bus.req0_ready}, onehot(g)); end
      want = alu_ref(cur_op[g], cur_a[g], cur_b[g]);
      step(); rand_req(g);
      step(); #1;
      got   = (g == 1) ? bus.resp1_data : bus.resp0_data;
      other = (g == 1) ? bus.resp0_data : bus.resp1_data;
      checks++; if ({bus.resp1_valid, bus.resp0_valid} !== onehot(g)) begin errors++; $display("FAIL rr_resp_valid op%0d got=%b exp=%b", i, {bus.resp1_valid, bus.resp0_valid}, onehot(g)); end
      checks++; if (got !== want || other !== '0) begin errors++; $display("FAIL rr_resp_data op%0d got=%h other=%h exp=%h other=0", i, got, other, want); end
      step();
    end
    quiet();
    model_last = 1'b1;
  endtask

  task automatic test_backpressure();
    quiet(); step();
    set_req(1, 4'd7, 32'h8000_0000, 32'd4, 1'b1); #1;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin errors++; $display("FAIL bp_accept got=%b exp=10", {bus.req1_ready, bus.req0_ready}); end
    step();
    bus.req1_valid = 1'b0;
    set_req(0, 4'd0, 32'd1, 32'd1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(); #1;
      checks++; if ({bus.resp1_valid, bus.req0_ready, bus.req1_ready, busy} !== 4'b1001) begin errors++; $display("FAIL bp_hold_ctrl cyc%0d got=%b exp=1001", k, {bus.resp1_valid, bus.req0_ready, bus.req1_ready, busy}); end
      checks++; if (bus.resp1_data !== 32'hF800_0000) begin errors++; $display("FAIL bp_hold_data cyc%0d got=%h exp=f8000000", k, bus.resp1_data); end
    end
    bus.resp1_ready = 1'b1;
    step(); #1;
    checks++; if ({busy, bus.req0_ready, bus.resp1_valid} !== 3'b010) begin errors++; $display("FAIL bp_release got=%b exp=010", {busy, bus.req0_ready, bus.resp1_valid}); end
    quiet();
    model_last = 1'b1;
  endtask

  task automatic test_reset_mid_resp();
    quiet(); step();
    set_req(0, 4'd3, 32'hF0, 32'h0F, 1'b1);
    step(); bus.req0_valid = 1'b0;
    step(); #1;
    checks++; if (bus.resp0_valid !== 1'b1 || bus.resp0_data !== 32'hFF) begin errors++; $display("FAIL rst_pre_resp got=%b/%h exp=1/ff", bus.resp0_valid, bus.resp0_data); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, busy} !== 5'b0) begin errors++; $display("FAIL rst_mid_ctrl got=%b exp=00000", {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, busy}); end
    checks++; if ({bus.resp0_data, bus.alu_op1, bus.alu_op2, bus.alu_op} !== '0) begin errors++; $display("FAIL rst_mid_data got=%h exp=0", {bus.resp0_data, bus.alu_op1, bus.alu_op2, bus.alu_op}); end
    step();
    reset_n = 1'b1;
    model_last = 1'b1;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      checks++; if ({bus.resp0_valid, bus.resp1_valid, busy} !== 3'b000) begin errors++; $display("FAIL rst_no_resp cyc%0d got=%b exp=000", k, {bus.resp0_valid, bus.resp1_valid, busy}); end
    end
    quiet();
  endtask

  task automatic test_illegal_op();
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = $urandom; b = $urandom;
    quiet(); step();
    set_req(0, 4'd12, a, b, 1'b1); bus.resp0_ready = 1'b1; #1;
    checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL ill_accept got=%b exp=1", bus.req0_ready); end
    step(); bus.req0_valid = 1'b0; #1;
    checks++; if ({bus.alu_op, bus.alu_op1, bus.alu_op2} !== {4'd12, a, b}) begin errors++; $display("FAIL ill_forward got=%h exp=%h", {bus.alu_op, bus.alu_op1, bus.alu_op2}, {4'd12, a, b}); end
    step(); #1;
    checks++; if (bus.resp0_valid !== 1'b1 || bus.resp0_data !== '0) begin errors++; $display("FAIL ill_resp got=%b/%h exp=1/0", bus.resp0_valid, bus.resp0_data); end
    step(); #1;
    checks++; if ({busy, bus.resp0_valid} !== 2'b00) begin errors++; $display("FAIL ill_complete got=%b exp=00", {busy, bus.resp0_valid}); end
    quiet();
    model_last = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      bit v0;
      bit v1;
      int g;
      int stall;
      logic [W-1:0] want;
      logic [W-1:0] got;
      logic [3:0] op_s;
      step(); quiet();
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      rand_req(0); rand_req(1);
      bus.req0_valid = v0; bus.req1_valid = v1; #1;
      g = (v0 && v1) ? (model_last ? 0 : 1) : (v1 ? 1 : 0);
      checks++; if ({bus.req1_ready, bus.req0_ready} !== onehot(g)) begin errors++; $display("FAIL rand_grant op%0d got=%b exp=%b", n, {bus.req1_ready, bus.req0_ready}, onehot(g)); end
      model_last = (g == 1);
      want = alu_ref(cur_op[g], cur_a[g], cur_b[g]);
      op_s = cur_op[g];
      step();
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      if (g == 0) bus.resp1_ready = 1'($urandom_range(0, 1));
      else        bus.resp0_ready = 1'($urandom_range(0, 1));
      #1;
      checks++; if ({busy, bus.alu_op} !== {1'b1, op_s}) begin errors++; $display("FAIL rand_exec op%0d got=%h exp=%h", n, {busy, bus.alu_op}, {1'b1, op_s}); end
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        step(); #1;
        got = (g == 1) ? bus.resp1_data : bus.resp0_data;
        checks++; if ({bus.resp1_valid, bus.resp0_valid} !== onehot(g) || got !== want) begin errors++; $display("FAIL rand_resp op%0d cyc%0d got=%b/%h exp=%b/%h", n, s, {bus.resp1_valid, bus.resp0_valid}, got, onehot(g), want); end
      end
      if (g == 0) bus.resp0_ready = 1'b1;
      else        bus.resp1_ready = 1'b1;
      step(); #1;
      checks++; if ({busy, bus.resp0_valid, bus.resp1_valid} !== 3'b000) begin errors++; $display("FAIL rand_done op%0d got=%b exp=000", n, {busy, bus.resp0_valid, bus.resp1_valid}); end
    end
    quiet();
  endtask

  initial begin
    reset_n = 1'b0;
    quiet();
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_backpressure();
    test_reset_mid_resp();
    test_illegal_op();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
